// File: rtl/iter_shifter.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROL by a runtime amount, up to STEP positions per clock.
// Driven through a start/busy/done handshake; out holds the last result until the next accepted start.
module iter_shifter #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4,
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   out
);

    // One extra bit so STEP itself (which may equal 2^SHAMT_W) is representable.
    localparam int CNT_W = SHAMT_W + 1;
    localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [CNT_W-1:0]        step_k;
    logic [CNT_W-1:0]        rem_after;
    logic [WIDTH-1:0]        acc_shift;
    logic [STEP:0][WIDTH-1:0] cand;
    logic signed [WIDTH-1:0] acc_s;

    assign acc_s = acc_q;

    // cand[j] is the accumulator shifted by exactly j positions in the latched mode.
    genvar gi;
    generate
        for (gi = 0; gi <= STEP; gi++) begin : g_cand
            if (gi == 0) begin : g_zero
                assign cand[gi] = acc_q;
            end else begin : g_shift
                logic [WIDTH-1:0] sra_v;
                logic [WIDTH-1:0] rol_v;
                // Kept in its own signed assignment so the shift stays arithmetic.
                assign sra_v = acc_s >>> gi;
                assign rol_v = (acc_q << gi) | (acc_q >> (WIDTH - gi));
                assign cand[gi] = (mode_q == MODE_SLL) ? (acc_q << gi) :
                                  (mode_q == MODE_SRL) ? (acc_q >> gi) :
                                  (mode_q == MODE_SRA) ? sra_v : rol_v;
            end
        end
    endgenerate

    always_comb begin
        step_k    = (rem_q < STEP_C) ? rem_q : STEP_C;
        rem_after = rem_q - step_k;
        acc_shift = acc_q;
        for (int j = 1; j <= STEP; j++) begin
            if (step_k == CNT_W'(j)) begin
                acc_shift = cand[j];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_SHIFT: begin
                acc_d = acc_shift;
                rem_d = rem_after;
                if (rem_after == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                if (start) begin
                    mode_d = mode;
                    acc_d  = in;
                    if (shamt == '0) begin
                        rem_d   = '0;
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        rem_d   = {1'b0, shamt};
                        state_d = S_SHIFT;
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = acc_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter: STEP=1 and STEP=4 instances, vector table plus handshake corner cases.
module tb_iter_shifter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start1, start4;
    logic [1:0]  mode;
    logic [15:0] in_v;
    logic [3:0]  shamt;
    logic        busy1, done1, busy4, done4;
    logic [15:0] out1, out4;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    iter_shifter #(.WIDTH(16), .SHAMT_W(4), .STEP(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .mode(mode), .in(in_v),
        .shamt(shamt), .busy(busy1), .done(done1), .out(out1)
    );

    iter_shifter #(.WIDTH(16), .SHAMT_W(4), .STEP(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .mode(mode), .in(in_v),
        .shamt(shamt), .busy(busy4), .done(done4), .out(out4)
    );

    typedef struct {
        int          sel;      // 0: STEP=1 instance, 1: STEP=4 instance
        logic [1:0]  mode;
        logic [15:0] a;
        logic [3:0]  s;
        logic [15:0] exp;
        int          n;        // expected edges from start to done
    } vec_t;

    vec_t vecs[15];

    function automatic logic get_done(input int sel);
        return (sel == 0) ? done1 : done4;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy1 : busy4;
    endfunction

    function automatic logic [15:0] get_out(input int sel);
        return (sel == 0) ? out1 : out4;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start1 = v;
        else          start4 = v;
    endtask

    // Drives start across one edge; returns the cycle stamp of the accepting edge.
    task automatic issue(input int sel, input logic [1:0] m, input logic [15:0] a,
                         input logic [3:0] s, output int k_cyc);
        @(negedge clk);
        mode = m; in_v = a; shamt = s;
        set_start(sel, 1'b1);
        @(posedge clk);
        #1;
        k_cyc = cyc;
        set_start(sel, 1'b0);
    endtask

    // Called #1 after an edge; waits (bounded) for done, counting busy cycles and overlaps.
    task automatic wait_done(input int sel, output int done_cyc, output int bcnt, output int both);
        int guard;
        guard = 0; bcnt = 0; both = 0;
        while (!get_done(sel) && guard < 64) begin
            if (get_busy(sel)) bcnt++;
            @(posedge clk);
            #1;
            guard++;
        end
        if (get_done(sel) && get_busy(sel)) both++;
        done_cyc = cyc;
    endtask

    task automatic run_vec(input int idx);
        int k_cyc, d_cyc, bcnt, both;
        vec_t v;
        v = vecs[idx];
        issue(v.sel, v.mode, v.a, v.s, k_cyc);
        wait_done(v.sel, d_cyc, bcnt, both);
        check($sformatf("v%0d latency", idx), d_cyc - k_cyc, v.n);
        check($sformatf("v%0d busy_cycles", idx), bcnt, v.n);
        check($sformatf("v%0d out", idx), get_out(v.sel), v.exp);
        check($sformatf("v%0d busy_done_overlap", idx), both, 0);
        @(posedge clk);
        #1;
        check($sformatf("v%0d done_single", idx), get_done(v.sel), 1'b0);
        check($sformatf("v%0d out_hold", idx), get_out(v.sel), v.exp);
    endtask

    initial begin
        int k_cyc, d_cyc, bcnt, both, dcount;

        vecs[0]  = '{0, 2'b00, 16'h0037, 4'd8,  16'h3700, 8};
        vecs[1]  = '{0, 2'b00, 16'h0015, 4'd8,  16'h1500, 8};
        vecs[2]  = '{0, 2'b00, 16'h00FF, 4'd8,  16'hFF00, 8};
        vecs[3]  = '{0, 2'b10, 16'h8000, 4'd15, 16'hFFFF, 15};
        vecs[4]  = '{0, 2'b01, 16'h8000, 4'd15, 16'h0001, 15};
        vecs[5]  = '{0, 2'b11, 16'h8001, 4'd4,  16'h0018, 4};
        vecs[6]  = '{1, 2'b00, 16'h00FF, 4'd8,  16'hFF00, 2};
        vecs[7]  = '{1, 2'b01, 16'hF000, 4'd5,  16'h0780, 2};
        vecs[8]  = '{0, 2'b10, 16'h1234, 4'd0,  16'h1234, 0};
        vecs[9]  = '{1, 2'b11, 16'h1234, 4'd7,  16'h1A09, 2};
        vecs[10] = '{1, 2'b10, 16'h9000, 4'd13, 16'hFFFC, 4};
        vecs[11] = '{0, 2'b10, 16'h4000, 4'd3,  16'h0800, 3};
        vecs[12] = '{1, 2'b11, 16'h8001, 4'd15, 16'hC000, 4};
        vecs[13] = '{0, 2'b00, 16'hFFFF, 4'd15, 16'h8000, 15};
        vecs[14] = '{1, 2'b01, 16'hABCD, 4'd0,  16'hABCD, 0};

        reset = 1'b1; start1 = 1'b0; start4 = 1'b0;
        mode = 2'b00; in_v = 16'h0; shamt = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out1", out1, 16'h0);
        check("reset busy1", busy1, 1'b0);
        check("reset done1", done1, 1'b0);
        check("reset out4", out4, 16'h0);
        check("reset busy4", busy4, 1'b0);
        check("reset done4", done4, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) run_vec(i);

        // Back-to-back: start held through the DONE cycle of a zero-shift op.
        @(negedge clk);
        mode = 2'b10; in_v = 16'h1234; shamt = 4'd0; start1 = 1'b1;
        @(posedge clk);
        #1;
        check("b2b first done", done1, 1'b1);
        check("b2b first busy", busy1, 1'b0);
        check("b2b first out", out1, 16'h1234);
        @(negedge clk);
        mode = 2'b00; in_v = 16'h0001; shamt = 4'd3;
        @(posedge clk);
        #1;
        k_cyc = cyc;
        start1 = 1'b0;
        check("b2b second accepted", busy1, 1'b1);
        wait_done(0, d_cyc, bcnt, both);
        check("b2b second latency", d_cyc - k_cyc, 3);
        check("b2b second out", out1, 16'h0008);

        // Start pulsed mid-SHIFT with other operands must be ignored.
        issue(0, 2'b00, 16'h0037, 4'd8, k_cyc);
        repeat (3) @(posedge clk);
        @(negedge clk);
        mode = 2'b01; in_v = 16'hFFFF; shamt = 4'd1; start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        wait_done(0, d_cyc, bcnt, both);
        check("ignore latency", d_cyc - k_cyc, 8);
        check("ignore out", out1, 16'h3700);
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done1) dcount++;
        end
        check("ignore single done", dcount, 0);

        // Reset during cycle 3 of an 8-cycle SLL abandons the operation.
        issue(0, 2'b00, 16'h0037, 4'd8, k_cyc);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset out", out1, 16'h0);
        check("midreset busy", busy1, 1'b0);
        check("midreset done", done1, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done1 || busy1) dcount++;
        end
        check("midreset no done", dcount, 0);
        issue(0, 2'b11, 16'h8001, 4'd4, k_cyc);
        wait_done(0, d_cyc, bcnt, both);
        check("postreset latency", d_cyc - k_cyc, 4);
        check("postreset out", out1, 16'h0018);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/iter_shifter.md
# iter_shifter

Parametrised multi-cycle shifter for the datapath, replacing the fixed 8-bit-to-16-bit left-by-8 immediate shifter. It performs logical-left, logical-right, arithmetic-right or rotate-left shifts by a runtime amount. It processes up to STEP bit positions per clock, so area and speed can be traded without changing the interface. It sits beside the ALU and is driven by the control unit through a start/busy/done handshake.

## Interface
- WIDTH, 16, data width in bits (≥ 2)
- SHAMT_W, 4, shift-amount width; WIDTH ≤ 2^SHAMT_W
- STEP, 1, maximum bit positions shifted per clock (1 ≤ STEP ≤ WIDTH)

- clk  input  1  rising-edge clock, the only clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy = 0
- mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL; captured with start
- in  input  WIDTH  operand; captured with start
- shamt  input  SHAMT_W  shift amount; captured with start; values ≥ WIDTH are legal
- busy  output  1  high while shifting
- done  output  1  one-cycle pulse when out is valid
- out  output  WIDTH  result register; holds until the next accepted start

## Operation
- The block has three states: IDLE, SHIFT and DONE.
- Reset values: state = IDLE, out = 0, busy = 0, done = 0, internal remaining count = 0.
- **IDLE or DONE with start = 1:**
  - Latch mode and shamt; load the accumulator (out) with in.
  - If shamt = 0, go to DONE.
  - Otherwise, set remaining = shamt and go to SHIFT.
- **IDLE or DONE with start = 0:** go to (or stay in) IDLE. out holds its value.
- **SHIFT:** each clock, shift out by k = min(STEP, remaining) positions and decrement remaining by k. When remaining reaches 0, go to DONE.
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - SRA: fill with bit WIDTH-1 of the accumulator, i.e. the sign of the latched operand, which persists.
  - ROL: bits leaving the MSB enter at the LSB.
- Amounts ≥ WIDTH:
  - SLL and SRL produce 0.
  - SRA produces all copies of the sign bit.
  - ROL wraps modulo WIDTH. The hardware still iterates the full shamt; no short-circuit is required, but the result must match.
- start is ignored while busy = 1. in, mode and shamt changes during SHIFT have no effect.
- DONE lasts exactly one cycle. A start in DONE is accepted, which allows back-to-back operations with no IDLE gap.
- Reset asserted in any state takes effect at the next edge and returns all reset values. An in-flight operation is abandoned and produces no done pulse.

## Timing
- Let N = ceil(shamt / STEP), and let edge k be the edge at which start is accepted.
- busy = 1 in the cycles after edges k … k+N-1. It is 0 for shamt = 0.
- done = 1, with out valid, in the cycle after edge k+N.
- shamt = 0 gives done after edge k, i.e. 1-cycle latency.
- Total latency from the start edge to the done cycle is N+1 clocks. Throughput is one operation per N+1 clocks.
- busy and done are registered outputs, never both high.
- out changes only at accepted-start edges, SHIFT edges and reset.

## Test plan
- WIDTH=16, STEP=1. SLL in=0x0037, shamt=8 -> busy high for 8 cycles; done after edge k+8; out=0x3700. Repeat with 0x0015 -> 0x1500 and 0x00FF -> 0xFF00.
- SRA in=0x8000, shamt=15 -> out=0xFFFF. SRL with the same operands -> out=0x0001. ROL in=0x8001, shamt=4 -> out=0x0018.
- STEP=4. SLL in=0x00FF, shamt=8 -> done after edge k+2, out=0xFF00. SRL in=0xF000, shamt=5 -> steps of 4 then 1; done after edge k+2; out=0x0780.
- shamt=0, SRA in=0x1234 -> busy never rises; done in the cycle after the start edge; out=0x1234. A back-to-back start during that DONE cycle is accepted and completes correctly.
- Start pulsed during SHIFT with different operands -> ignored. The original result appears with a single done pulse.
- Reset asserted mid-SHIFT (for example, cycle 3 of an 8-cycle SLL) -> the next cycle shows out=0, busy=0, done=0, with no subsequent done. A new start then completes normally.
